// File: rtl/axi_reg_slice.sv
// Full-throughput AXI4 register slice: every channel is output-registered with a skid buffer.
// Latency is one cycle per beat. Upstream ready comes from a flop and drops only when the skid holds a beat.
module axi_reg_slice #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8
) (
    input  logic                  uncoreclk,
    input  logic                  uncorerstn,
    // slave side, toward the master
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // master side, toward the address mapper
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [ID_W-1:0]       m_axi_arid,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [ID_W-1:0]       m_axi_rid,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ax_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic              last;
    } r_t;

    ax_t s_aw, m_aw, s_ar, m_ar;
    w_t  s_w, m_w;
    b_t  s_b, m_b;
    r_t  s_r, m_r;

    assign s_aw = '{addr: s_axi_awaddr, id: s_axi_awid, len: s_axi_awlen,
                    size: s_axi_awsize, burst: s_axi_awburst};
    assign s_ar = '{addr: s_axi_araddr, id: s_axi_arid, len: s_axi_arlen,
                    size: s_axi_arsize, burst: s_axi_arburst};
    assign s_w  = '{data: s_axi_wdata, strb: s_axi_wstrb, last: s_axi_wlast};
    assign m_b  = '{id: m_axi_bid, resp: m_axi_bresp};
    assign m_r  = '{data: m_axi_rdata, id: m_axi_rid, resp: m_axi_rresp, last: m_axi_rlast};

    assign m_axi_awaddr  = m_aw.addr;
    assign m_axi_awid    = m_aw.id;
    assign m_axi_awlen   = m_aw.len;
    assign m_axi_awsize  = m_aw.size;
    assign m_axi_awburst = m_aw.burst;
    assign m_axi_araddr  = m_ar.addr;
    assign m_axi_arid    = m_ar.id;
    assign m_axi_arlen   = m_ar.len;
    assign m_axi_arsize  = m_ar.size;
    assign m_axi_arburst = m_ar.burst;
    assign m_axi_wdata   = m_w.data;
    assign m_axi_wstrb   = m_w.strb;
    assign m_axi_wlast   = m_w.last;
    assign s_axi_bid     = s_b.id;
    assign s_axi_bresp   = s_b.resp;
    assign s_axi_rdata   = s_r.data;
    assign s_axi_rid     = s_r.id;
    assign s_axi_rresp   = s_r.resp;
    assign s_axi_rlast   = s_r.last;

    axi_reg_slice_chan #(.W($bits(ax_t))) u_aw (
        .clk(uncoreclk), .rst_n(uncorerstn),
        .up_vld(s_axi_awvalid), .up_dat(s_aw), .up_rdy(s_axi_awready),
        .dn_vld(m_axi_awvalid), .dn_dat(m_aw), .dn_rdy(m_axi_awready)
    );

    axi_reg_slice_chan #(.W($bits(w_t))) u_w (
        .clk(uncoreclk), .rst_n(uncorerstn),
        .up_vld(s_axi_wvalid), .up_dat(s_w), .up_rdy(s_axi_wready),
        .dn_vld(m_axi_wvalid), .dn_dat(m_w), .dn_rdy(m_axi_wready)
    );

    axi_reg_slice_chan #(.W($bits(b_t))) u_b (
        .clk(uncoreclk), .rst_n(uncorerstn),
        .up_vld(m_axi_bvalid), .up_dat(m_b), .up_rdy(m_axi_bready),
        .dn_vld(s_axi_bvalid), .dn_dat(s_b), .dn_rdy(s_axi_bready)
    );

    axi_reg_slice_chan #(.W($bits(ax_t))) u_ar (
        .clk(uncoreclk), .rst_n(uncorerstn),
        .up_vld(s_axi_arvalid), .up_dat(s_ar), .up_rdy(s_axi_arready),
        .dn_vld(m_axi_arvalid), .dn_dat(m_ar), .dn_rdy(m_axi_arready)
    );

    axi_reg_slice_chan #(.W($bits(r_t))) u_r (
        .clk(uncoreclk), .rst_n(uncorerstn),
        .up_vld(m_axi_rvalid), .up_dat(m_r), .up_rdy(m_axi_rready),
        .dn_vld(s_axi_rvalid), .dn_dat(s_r), .dn_rdy(s_axi_rready)
    );

endmodule

// One channel of the slice: OUT register plus SKID register, payload-agnostic.
// Both valid and ready leave straight from flops, so no input reaches an output combinationally.
module axi_reg_slice_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_vld,
    input  logic [W-1:0] up_dat,
    output logic         up_rdy,
    output logic         dn_vld,
    output logic [W-1:0] dn_dat,
    input  logic         dn_rdy
);

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t         state_q, state_d;
    logic           vld_q, vld_d;
    logic           rdy_q, rdy_d;
    logic [W-1:0]   out_q, out_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           acc_in, acc_out;

    always_comb begin
        acc_in  = up_vld & rdy_q;
        acc_out = vld_q & dn_rdy;
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc_in) begin
                    out_d   = up_dat;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (acc_in && acc_out) begin
                    out_d = up_dat;
                end else if (acc_in) begin
                    skid_d  = up_dat;
                    state_d = FULL;
                end else if (acc_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready is low here, so the skid beat always drains before any new input
                if (acc_out) begin
                    out_d   = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        vld_d = (state_d != EMPTY);
        rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload needs no reset: it is only observed while the matching valid is set.
    always_ff @(posedge clk) begin
        out_q  <= out_d;
        skid_q <= skid_d;
    end

    assign up_rdy = rdy_q;
    assign dn_vld = vld_q;
    assign dn_dat = out_q;

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: channels are addressed generically (0 AW, 1 W, 2 B, 3 AR, 4 R) as up/dn ends.
module tb_axi_reg_slice;

    logic uncoreclk = 1'b0;
    logic uncorerstn;
    always #5 uncoreclk = ~uncoreclk;

    logic [31:0] s_axi_awaddr, m_axi_awaddr, s_axi_araddr, m_axi_araddr;
    logic [7:0]  s_axi_awid, m_axi_awid, s_axi_arid, m_axi_arid;
    logic [7:0]  s_axi_awlen, m_axi_awlen, s_axi_arlen, m_axi_arlen;
    logic [2:0]  s_axi_awsize, m_axi_awsize, s_axi_arsize, m_axi_arsize;
    logic [1:0]  s_axi_awburst, m_axi_awburst, s_axi_arburst, m_axi_arburst;
    logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
    logic [7:0]  s_axi_wstrb, m_axi_wstrb;
    logic        s_axi_wlast, m_axi_wlast, s_axi_rlast, m_axi_rlast;
    logic        s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
    logic [7:0]  s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
    logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
    logic        s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;

    logic        up_vld [5];
    logic [79:0] up_dat [5];
    logic        up_rdy [5];
    logic        dn_vld [5];
    logic [79:0] dn_dat [5];
    logic        dn_rdy [5];

    // AW
    assign {s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst} = up_dat[0][52:0];
    assign s_axi_awvalid = up_vld[0];
    assign up_rdy[0]     = s_axi_awready;
    assign dn_vld[0]     = m_axi_awvalid;
    assign dn_dat[0]     = {27'd0, m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst};
    assign m_axi_awready = dn_rdy[0];
    // W
    assign {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = up_dat[1][72:0];
    assign s_axi_wvalid = up_vld[1];
    assign up_rdy[1]    = s_axi_wready;
    assign dn_vld[1]    = m_axi_wvalid;
    assign dn_dat[1]    = {7'd0, m_axi_wdata, m_axi_wstrb, m_axi_wlast};
    assign m_axi_wready = dn_rdy[1];
    // B (reverse)
    assign {m_axi_bid, m_axi_bresp} = up_dat[2][9:0];
    assign m_axi_bvalid = up_vld[2];
    assign up_rdy[2]    = m_axi_bready;
    assign dn_vld[2]    = s_axi_bvalid;
    assign dn_dat[2]    = {70'd0, s_axi_bid, s_axi_bresp};
    assign s_axi_bready = dn_rdy[2];
    // AR
    assign {s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst} = up_dat[3][52:0];
    assign s_axi_arvalid = up_vld[3];
    assign up_rdy[3]     = s_axi_arready;
    assign dn_vld[3]     = m_axi_arvalid;
    assign dn_dat[3]     = {27'd0, m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst};
    assign m_axi_arready = dn_rdy[3];
    // R (reverse)
    assign {m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast} = up_dat[4][74:0];
    assign m_axi_rvalid = up_vld[4];
    assign up_rdy[4]    = m_axi_rready;
    assign dn_vld[4]    = s_axi_rvalid;
    assign dn_dat[4]    = {5'd0, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast};
    assign s_axi_rready = dn_rdy[4];

    axi_reg_slice dut (
        .uncoreclk(uncoreclk), .uncorerstn(uncorerstn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_bit(input string name, input logic act, input logic exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp_v, $time);
    endtask

    task automatic check_dat(input string name, input logic [79:0] act, input logic [79:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
    endtask

    task automatic tick();
        @(posedge uncoreclk);
        #1;
    endtask

    function automatic logic [79:0] ax_pk(input logic [31:0] addr, input logic [7:0] id);
        return {27'd0, addr, id, 8'd0, 3'd3, 2'd1};
    endfunction

    function automatic logic [79:0] w_pk(input logic [63:0] data, input logic last);
        return {7'd0, data, 8'hFF, last};
    endfunction

    function automatic logic [79:0] mask_of(input int ch);
        case (ch)
            1:       return {7'd0, {73{1'b1}}};
            2:       return {70'd0, {10{1'b1}}};
            4:       return {5'd0, {75{1'b1}}};
            default: return {27'd0, {53{1'b1}}};
        endcase
    endfunction

    task automatic check_idle(input string tag);
        for (int ch = 0; ch < 5; ch++) begin
            check_bit({tag, "_vld"}, dn_vld[ch], 1'b0);
            check_bit({tag, "_rdy"}, up_rdy[ch], 1'b1);
        end
    endtask

    typedef struct {
        logic        s_vld;
        logic [79:0] s_dat;
        logic        m_rdy;
        logic        exp_m_vld;
        logic [79:0] exp_m_dat;
        logic        exp_s_rdy;
    } wvec_t;

    wvec_t wv [7];

    // stress scoreboard: at most two beats can be in flight per channel
    logic [79:0] sb [5][4];
    int          wp [5];
    int          rp [5];
    logic        pend [5];
    logic        stall [5];
    logic [79:0] stall_dat [5];

    task automatic stress_step(input logic drain);
        for (int ch = 0; ch < 5; ch++) begin
            if (stall[ch]) begin
                check_bit("stall_vld", dn_vld[ch], 1'b1);
                check_dat("stall_dat", dn_dat[ch], stall_dat[ch]);
            end
            if (!pend[ch]) begin
                up_vld[ch] = drain ? 1'b0 : 1'($urandom_range(0, 1));
                up_dat[ch] = 80'({$urandom, $urandom, $urandom}) & mask_of(ch);
            end
            dn_rdy[ch]    = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
            pend[ch]      = up_vld[ch] & ~up_rdy[ch];
            stall[ch]     = dn_vld[ch] & ~dn_rdy[ch];
            stall_dat[ch] = dn_dat[ch];
            if (dn_vld[ch] && dn_rdy[ch]) begin
                check_bit("sb_has_beat", wp[ch] != rp[ch], 1'b1);
                if (wp[ch] != rp[ch]) begin
                    check_dat("sb_payload", dn_dat[ch], sb[ch][rp[ch] % 4]);
                    rp[ch]++;
                end
            end
            if (up_vld[ch] && up_rdy[ch]) begin
                check_bit("sb_occupancy", (wp[ch] - rp[ch]) < 3, 1'b1);
                sb[ch][wp[ch] % 4] = up_dat[ch];
                wp[ch]++;
            end
        end
        tick();
    endtask

    initial begin
        uncorerstn = 1'b0;
        for (int ch = 0; ch < 5; ch++) begin
            up_vld[ch] = 1'b0;
            up_dat[ch] = '0;
            dn_rdy[ch] = 1'b1;
            wp[ch] = 0; rp[ch] = 0;
            pend[ch] = 1'b0; stall[ch] = 1'b0; stall_dat[ch] = '0;
        end

        wv[0] = '{1'b1, w_pk(64'hA0, 1'b0), 1'b0, 1'b1, w_pk(64'hA0, 1'b0), 1'b1};
        wv[1] = '{1'b1, w_pk(64'hA1, 1'b0), 1'b0, 1'b1, w_pk(64'hA0, 1'b0), 1'b0};
        wv[2] = '{1'b1, w_pk(64'hA2, 1'b0), 1'b0, 1'b1, w_pk(64'hA0, 1'b0), 1'b0};
        wv[3] = '{1'b1, w_pk(64'hA2, 1'b0), 1'b1, 1'b1, w_pk(64'hA1, 1'b0), 1'b1};
        wv[4] = '{1'b1, w_pk(64'hA2, 1'b0), 1'b1, 1'b1, w_pk(64'hA2, 1'b0), 1'b1};
        wv[5] = '{1'b1, w_pk(64'hA3, 1'b1), 1'b1, 1'b1, w_pk(64'hA3, 1'b1), 1'b1};
        wv[6] = '{1'b0, w_pk(64'hA3, 1'b1), 1'b1, 1'b0, w_pk(64'hA3, 1'b1), 1'b1};

        // reset state, held across clock edges
        #12;
        check_idle("rst_a");
        #10;
        check_idle("rst_b");
        #9 uncorerstn = 1'b1;
        tick();

        // AR streaming with downstream always ready
        for (int i = 0; i < 8; i++) begin
            up_vld[3] = 1'b1;
            up_dat[3] = ax_pk(32'h1000 + 32'(i * 8), 8'(i));
            tick();
            check_bit("ar_vld", dn_vld[3], 1'b1);
            check_dat("ar_dat", dn_dat[3], ax_pk(32'h1000 + 32'(i * 8), 8'(i)));
            check_bit("ar_rdy", up_rdy[3], 1'b1);
        end
        up_vld[3] = 1'b0;
        tick();
        check_bit("ar_idle", dn_vld[3], 1'b0);

        // W burst against backpressure
        for (int i = 0; i < 7; i++) begin
            up_vld[1] = wv[i].s_vld;
            up_dat[1] = wv[i].s_dat;
            dn_rdy[1] = wv[i].m_rdy;
            tick();
            check_bit("w_m_vld", dn_vld[1], wv[i].exp_m_vld);
            if (wv[i].exp_m_vld) check_dat("w_m_dat", dn_dat[1], wv[i].exp_m_dat);
            check_bit("w_s_rdy", up_rdy[1], wv[i].exp_s_rdy);
        end

        // R beat stalled for 10 cycles
        dn_rdy[4] = 1'b0;
        up_vld[4] = 1'b1;
        up_dat[4] = {5'd0, 64'hDEADBEEF, 8'd3, 2'd0, 1'b1};
        tick();
        up_vld[4] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_bit("r_stall_vld", dn_vld[4], 1'b1);
            check_dat("r_stall_dat", dn_dat[4], {5'd0, 64'hDEADBEEF, 8'd3, 2'd0, 1'b1});
            tick();
        end
        dn_rdy[4] = 1'b1;
        check_bit("r_hs_vld", dn_vld[4], 1'b1);
        tick();
        check_bit("r_done", dn_vld[4], 1'b0);

        // random stress then drain
        for (int i = 0; i < 10000; i++) stress_step(1'b0);
        for (int i = 0; i < 8; i++) stress_step(1'b1);
        for (int ch = 0; ch < 5; ch++) check_bit("sb_drained", wp[ch] == rp[ch], 1'b1);

        // reset while AW and B are both full
        for (int ch = 0; ch < 5; ch++) begin
            up_vld[ch] = 1'b0;
            dn_rdy[ch] = 1'b1;
        end
        dn_rdy[0] = 1'b0;
        dn_rdy[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            up_vld[0] = 1'b1;
            up_dat[0] = ax_pk(32'h2000 + 32'(k * 4), 8'(k));
            up_vld[2] = 1'b1;
            up_dat[2] = {70'd0, 8'(8'h40 + k), 2'b01};
            tick();
        end
        check_bit("aw_full_rdy", up_rdy[0], 1'b0);
        check_bit("b_full_rdy", up_rdy[2], 1'b0);
        up_vld[0] = 1'b0;
        up_vld[2] = 1'b0;
        #3 uncorerstn = 1'b0;
        #1;
        check_idle("midrst");
        tick();
        check_idle("midrst_hold");
        #2 uncorerstn = 1'b1;
        dn_rdy[0] = 1'b1;
        dn_rdy[2] = 1'b1;
        up_vld[0] = 1'b1;
        up_dat[0] = ax_pk(32'h3000, 8'h5A);
        #1;
        check_bit("post_rst_pre", dn_vld[0], 1'b0);
        tick();
        check_bit("post_rst_vld", dn_vld[0], 1'b1);
        check_dat("post_rst_dat", dn_dat[0], ax_pk(32'h3000, 8'h5A));
        up_vld[0] = 1'b0;
        tick();
        check_bit("post_rst_idle", dn_vld[0], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
